// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and sizing helpers for the sram port arbiter.
package sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OWNER_W_DEFAULT = idx_w(2);

endpackage

// File: rtl/sram_port_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above the pointer, wrapping.
module rr_picker
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = OWNER_W_DEFAULT
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [IW-1:0]      o_winner,
    output logic               o_any
);

    // Walk candidates from farthest to nearest so the nearest one wins.
    always_comb begin
        int j;
        o_winner = '0;
        o_any    = 1'b0;
        j        = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (i_req[j]) begin
                o_winner = IW'(j);
                o_any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port sram sharing between NUM_REQ requesters with round-robin
// arbitration, locked bursts capped at MAX_BURST when others wait, and
// read-data return tagged to the issuing requester.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ-1:0]            i_lock,
    input  logic [NUM_REQ-1:0]            i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_wdata,
    output logic [NUM_REQ-1:0]            o_gnt,
    output logic [NUM_REQ-1:0]            o_rvalid,
    output logic [DATA_WIDTH-1:0]         o_rdata,
    output logic                          o_mem_cs,
    output logic                          o_mem_we,
    output logic [ADDR_WIDTH-1:0]         o_mem_addr,
    output logic [DATA_WIDTH-1:0]         o_mem_din,
    input  logic [DATA_WIDTH-1:0]         i_mem_dout
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = idx_w(MAX_BURST);

    arb_state_t         r_state, w_state_nxt;
    logic [IW-1:0]      r_owner, w_owner_nxt;
    logic [IW-1:0]      r_ptr, w_ptr_nxt;
    logic [BW-1:0]      r_burst, w_burst_nxt;
    logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
    logic               r_rd_pend;
    logic [IW-1:0]      r_rd_tag;

    logic [NUM_REQ-1:0] w_own_mask, w_cand;
    logic [IW-1:0]      w_win, w_win_inc;
    logic               w_any, w_beat, w_last;

    // The current owner's request is stale once it releases, so it only
    // competes again through normal rotation on a later cycle.
    assign w_own_mask = (r_state == OWN) ? (NUM_REQ'(1) << r_owner) : '0;
    assign w_cand     = i_req & ~w_own_mask;
    assign w_beat     = (r_state == OWN) && i_req[r_owner];
    assign w_last     = (r_burst == BW'(MAX_BURST - 1));
    assign w_win_inc  = (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + IW'(1);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_picker (
        .i_req    (w_cand),
        .i_ptr    (r_ptr),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    // Next owner, pointer and burst count; hand-over happens with no bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_burst_nxt = r_burst;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = OWN;
                    w_owner_nxt = w_win;
                    w_ptr_nxt   = w_win_inc;
                    w_burst_nxt = '0;
                end
            end
            OWN: begin
                if (!w_beat || !i_lock[r_owner] || (w_last && w_any)) begin
                    w_burst_nxt = '0;
                    if (w_any) begin
                        w_owner_nxt = w_win;
                        w_ptr_nxt   = w_win_inc;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    // Alone and locked: count wraps and the grant is kept.
                    w_burst_nxt = w_last ? '0 : r_burst + BW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_burst_nxt = '0;
            end
        endcase
        w_gnt_nxt = (w_state_nxt == OWN) ? (NUM_REQ'(1) << w_owner_nxt) : '0;
    end

    // Arbitration state and read-return tag registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_burst   <= '0;
            r_gnt     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_tag  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_ptr     <= w_ptr_nxt;
            r_burst   <= w_burst_nxt;
            r_gnt     <= w_gnt_nxt;
            r_rd_pend <= w_beat && !i_we[r_owner];
            if (w_beat) r_rd_tag <= r_owner;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_rvalid   = r_rd_pend ? (NUM_REQ'(1) << r_rd_tag) : '0;
    assign o_rdata    = i_mem_dout;
    assign o_mem_cs   = w_beat;
    assign o_mem_we   = w_beat && i_we[r_owner];
    assign o_mem_addr = i_addr[r_owner*ADDR_WIDTH +: ADDR_WIDTH];
    assign o_mem_din  = i_wdata[r_owner*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous sram instance between NUM_REQ requesters, e.g. the matcher lookup path and the output writer in the encoder.
- Round-robin arbitration with optional locked bursts so that a matcher scan keeps the port.
- Muxes address, write enable and write data onto the sram, and routes read data back with a per-requester valid strobe.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_WIDTH, 4, sram address width
DATA_WIDTH, 8, sram data width
MAX_BURST, 16, maximum consecutive locked beats before forced re-arbitration when another requester waits

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
req  in  NUM_REQ  per-requester access request, held until granted
lock  in  NUM_REQ  requester wants to keep the grant after the current beat
we  in  NUM_REQ  per-requester write enable for the beat
addr  in  NUM_REQ*ADDR_WIDTH  flattened per-requester addresses, requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
wdata  in  NUM_REQ*DATA_WIDTH  flattened per-requester write data
gnt  out  NUM_REQ  registered one-hot grant
rvalid  out  NUM_REQ  registered, one cycle after a granted read beat, for the issuing requester
rdata  out  DATA_WIDTH  shared read data, equal to mem_dout, valid when any rvalid bit is set
mem_cs  out  1  sram chip select
mem_we  out  1  sram write enable
mem_addr  out  ADDR_WIDTH  sram address
mem_din  out  DATA_WIDTH  sram write data
mem_dout  in  DATA_WIDTH  sram read data, 1-cycle latency

Behaviour:
- Reset (rst=1, asynchronous):
  - State IDLE; gnt=0, rvalid=0.
  - rr pointer=0, burst count=0, read-owner tag=0.
  - mem_cs=0, mem_we=0.
- States:
  - IDLE: no owner.
  - OWN: owner index valid; gnt[owner]=1.
- Beat:
  - A beat is any cycle in OWN with req[owner]=1.
  - During a beat, combinationally: mem_cs=1, mem_we=we[owner], mem_addr=addr[owner], mem_din=wdata[owner].
  - When there is no beat: mem_cs=0, mem_we=0.
- Read return: a read beat (we[owner]=0) in cycle t gives rvalid[owner]=1 in cycle t+1, with rdata=mem_dout in that cycle. Writes never raise rvalid.
- Arbitration:
  - The winner is the first set req bit searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - On each grant, the pointer moves to winner+1, with modulo wrap.
- IDLE -> OWN: on any req set, the winner's gnt is set at the next edge. Latency is one cycle from req to gnt; the first beat happens in the first gnt cycle.
- OWN release (evaluated at the edge ending cycle t), when any of these holds:
  - req[owner]=0: no beat occurred;
  - the beat occurred with lock[owner]=0;
  - burst count reached MAX_BURST-1 on this beat and req has another bit set.
- On release:
  - If any req bit other than the releasing one's stale request is set, the winner is computed in the same cycle and the grant moves with no bubble. Otherwise go to IDLE.
  - The releasing requester may win again only via normal rr order.
- Burst count:
  - Increments on each locked beat and clears on grant change.
  - When it reaches MAX_BURST-1 and no other requester waits, it wraps to 0 and the grant is kept.
- gnt is always one-hot or zero. gnt and rvalid may belong to different requesters in the same cycle (hand-over right after a read).
- req deasserted by the owner mid-burst: no beat, release at that edge. A pending rvalid for its last read still fires.
- rst asserted mid-burst: all outputs clear immediately. In-flight rvalid is dropped.
- Out-of-range owner values cannot occur; the default branch returns to IDLE.

Decomposition:
- Package sram_arb_pkg:
  - enum arb_state {IDLE, OWN};
  - owner index width constant, $clog2(NUM_REQ) with a minimum of 1.
- Sub-module rr_picker: purely combinational. Inputs req and pointer; outputs winner index and any_valid.

Test Plan:
- Single requester 0 read, addr=4'h3, lock=0 -> gnt[0] one cycle after req; mem_cs=1, mem_addr=3, mem_we=0 in that cycle; next cycle rvalid=2'b01 and rdata=sram[3]; back to IDLE.
- req=2'b11 held with lock=0, pointer 0 -> grant sequence 0,1,0,1 with no idle cycles; each beat's mem_addr matches its requester.
- Requester 0 locked, requester 1 requesting, MAX_BURST=16 -> requester 0 gets exactly 16 consecutive beats, then gnt moves to requester 1 with no bubble.
- Requester 0 locked alone for 40 cycles -> gnt[0] stays high throughout; burst count wraps; mem_cs=1 every cycle.
- Requester 1 writes 8'hA5 to addr 7 -> mem_we=1, mem_din=A5; no rvalid. A later read of 7 by requester 0 returns A5 with rvalid=2'b01.
- rst pulsed during requester 0's locked burst -> gnt, rvalid and mem_cs are 0 during rst. After rst drops with req=2'b10, requester 1 is granted first (pointer reset to 0, only 1 requesting).
